// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, runs the imem req/ack handshake and
// presents one instruction at a time to decode. Optional: FETCH_MISALIGN_CHECK_EN.

// state   | meaning
// S_IDLE  | reset state, fetch starts next cycle
// S_FETCH | request outstanding at imem_addr
// S_HOLD  | instruction presented to decode
// S_DRAIN | discarding a stale in-flight response
// S_HALT  | absorbing until reset
module fetch_stage #(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc,
  input  logic        decode_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        halted,
  output logic        fetch_fault
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_HOLD,
    S_DRAIN,
    S_HALT
  } state_t;

  state_t      state, state_d;
  logic [31:0] pc, pc_d;
  logic [31:0] addr_q;
  logic        valid_d;
  logic        capture;
  logic        halt_pending, halt_pending_d;
  logic        halting;
  logic        redir_taken;
  logic        misalign;
  logic        stop;
  logic        redir_load;
  logic [31:0] redir_target;

  // a pending halt also blocks redirects so fetch never restarts once stopping
  assign halting     = halt || halt_pending;
  assign redir_taken = redirect && !halting && (state != S_HALT);

`ifdef FETCH_MISALIGN_CHECK_EN
  assign misalign     = redir_taken && (redirect_pc[1:0] != 2'b00);
  assign redir_target = redirect_pc;
`else
  assign misalign     = 1'b0;
  assign redir_target = redirect_pc & 32'hFFFF_FFFC;
`endif

  assign stop       = halting || misalign;
  assign redir_load = redir_taken && !misalign;

  always_comb begin
    state_d        = state;
    pc_d           = pc;
    valid_d        = instr_valid;
    capture        = 1'b0;
    halt_pending_d = halt_pending;
    case (state)
      S_IDLE: begin
        valid_d = 1'b0;
        if (stop) begin
          state_d = S_HALT;
        end else begin
          state_d = S_FETCH;
          if (redir_load) pc_d = redir_target;
        end
      end
      S_FETCH: begin
        if (stop) begin
          valid_d = 1'b0;
          if (imem_ack) begin
            state_d = S_HALT;
          end else begin
            state_d        = S_DRAIN;
            halt_pending_d = 1'b1;
          end
        end else if (redir_load) begin
          valid_d = 1'b0;
          pc_d    = redir_target;
          state_d = imem_ack ? S_FETCH : S_DRAIN;
        end else if (imem_ack) begin
          capture = 1'b1;
          pc_d    = pc + 32'd4;
          valid_d = 1'b1;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (stop) begin
          valid_d = 1'b0;
          state_d = S_HALT;
        end else if (redir_load) begin
          valid_d = 1'b0;
          pc_d    = redir_target;
          state_d = S_FETCH;
        end else if (decode_ready) begin
          valid_d = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_DRAIN: begin
        valid_d = 1'b0;
        if (stop) begin
          halt_pending_d = 1'b1;
          if (imem_ack) state_d = S_HALT;
        end else begin
          if (redir_load) pc_d = redir_target;
          if (imem_ack) state_d = S_FETCH;
        end
      end
      S_HALT: begin
        valid_d = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      pc           <= BOOT_ADDR;
      addr_q       <= BOOT_ADDR;
      instr_valid  <= 1'b0;
      instruction  <= NOP;
      instr_pc     <= BOOT_ADDR;
      halt_pending <= 1'b0;
      halted       <= 1'b0;
    end else begin
      state        <= state_d;
      pc           <= pc_d;
      instr_valid  <= valid_d;
      halt_pending <= halt_pending_d;
      halted       <= (state_d == S_HALT);
      // address only moves when a fresh request begins, never mid-request
      if (state_d == S_FETCH) addr_q <= pc_d;
      if (capture) begin
        instruction <= imem_rdata;
        instr_pc    <= pc;
      end
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) fetch_fault <= 1'b0;
    else if (misalign) fetch_fault <= 1'b1;
  end
`else
  assign fetch_fault = 1'b0;
`endif

  assign imem_req  = (state == S_FETCH) || (state == S_DRAIN);
  assign imem_addr = addr_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, zero-wait flow, decode stall,
// redirect drain, PC wrap, async reset, misaligned redirect and halt.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic        decode_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        halted;
  logic        fetch_fault;

  int total = 0;
  int bad   = 0;

  fetch_stage dut (
    .clk          (clk),
    .reset        (reset),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr_valid  (instr_valid),
    .instruction  (instruction),
    .instr_pc     (instr_pc),
    .decode_ready (decode_ready),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .halt         (halt),
    .halted       (halted),
    .fetch_fault  (fetch_fault)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"},   {31'd0, imem_req},    32'd0);
    chk({tag, "_addr"},  imem_addr,            32'h0000_1000);
    chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
    chk({tag, "_instr"}, instruction,          32'h0000_0013);
    chk({tag, "_ipc"},   instr_pc,             32'h0000_1000);
    chk({tag, "_halted"},{31'd0, halted},      32'd0);
    chk({tag, "_fault"}, {31'd0, fetch_fault}, 32'd0);
  endtask

  initial begin
    reset        = 1'b1;
    imem_ack     = 1'b0;
    imem_rdata   = 32'd0;
    decode_ready = 1'b0;
    redirect     = 1'b0;
    redirect_pc  = 32'd0;
    halt         = 1'b0;

    // reset state
    #12;
    chk_reset_vals("rst");

    // release reset: cycle 1 idle, cycle 2 first request
    tick;
    reset = 1'b0;
    chk("idle_req", {31'd0, imem_req}, 32'd0);
    tick;
    chk("f0_req",  {31'd0, imem_req}, 32'd1);
    chk("f0_addr", imem_addr, 32'h0000_1000);
    imem_ack = 1'b1; imem_rdata = 32'h0010_0093; decode_ready = 1'b1;
    tick;
    chk("h0_valid", {31'd0, instr_valid}, 32'd1);
    chk("h0_ipc",   instr_pc, 32'h0000_1000);
    chk("h0_instr", instruction, 32'h0010_0093);
    chk("h0_req",   {31'd0, imem_req}, 32'd0);
    imem_ack = 1'b0;
    tick;
    chk("f1_req",   {31'd0, imem_req}, 32'd1);
    chk("f1_addr",  imem_addr, 32'h0000_1004);
    chk("f1_valid", {31'd0, instr_valid}, 32'd0);
    imem_ack = 1'b1;
    tick;
    chk("h1_valid", {31'd0, instr_valid}, 32'd1);
    chk("h1_ipc",   instr_pc, 32'h0000_1004);

    // decode stall for 5 cycles
    imem_ack = 1'b0; decode_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("stall_valid", {31'd0, instr_valid}, 32'd1);
      chk("stall_ipc",   instr_pc, 32'h0000_1004);
      chk("stall_instr", instruction, 32'h0010_0093);
      chk("stall_req",   {31'd0, imem_req}, 32'd0);
    end
    decode_ready = 1'b1;
    tick;
    chk("resume_req",  {31'd0, imem_req}, 32'd1);
    chk("resume_addr", imem_addr, 32'h0000_1008);

    // redirect during outstanding request: address held, stale data dropped
    decode_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_2000;
    tick;
    redirect = 1'b0;
    chk("drain_req",   {31'd0, imem_req}, 32'd1);
    chk("drain_addr",  imem_addr, 32'h0000_1008);
    chk("drain_valid", {31'd0, instr_valid}, 32'd0);
    tick;
    chk("drain2_addr", imem_addr, 32'h0000_1008);
    tick;
    chk("drain3_addr", imem_addr, 32'h0000_1008);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick;
    chk("postdrain_addr",  imem_addr, 32'h0000_2000);
    chk("postdrain_req",   {31'd0, imem_req}, 32'd1);
    chk("postdrain_valid", {31'd0, instr_valid}, 32'd0);
    imem_rdata = 32'h1111_1111;
    tick;
    chk("rd_valid", {31'd0, instr_valid}, 32'd1);
    chk("rd_ipc",   instr_pc, 32'h0000_2000);
    chk("rd_instr", instruction, 32'h1111_1111);

    // redirect in HOLD wins over decode_ready; target at top of address space
    imem_ack = 1'b0; decode_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick;
    redirect = 1'b0;
    chk("hredir_valid", {31'd0, instr_valid}, 32'd0);
    chk("hredir_addr",  imem_addr, 32'hFFFF_FFFC);
    imem_ack = 1'b1; imem_rdata = 32'h2222_2222;
    tick;
    chk("top_ipc", instr_pc, 32'hFFFF_FFFC);
    imem_ack = 1'b0;
    tick;
    chk("wrap_addr", imem_addr, 32'h0000_0000);

    // asynchronous reset while in HOLD
    imem_ack = 1'b1; imem_rdata = 32'h3333_3333; decode_ready = 1'b0;
    tick;
    chk("pre_rst_ipc", instr_pc, 32'h0000_0000);
    imem_ack = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk_reset_vals("arst");
    tick;
    reset = 1'b0;
    tick;
    chk("restart_addr", imem_addr, 32'h0000_1000);
    chk("restart_req",  {31'd0, imem_req}, 32'd1);

    // misaligned redirect from HOLD
    imem_ack = 1'b1; imem_rdata = 32'h4444_4444;
    tick;
    imem_ack = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_2002;
    tick;
    redirect = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("mis_fault",  {31'd0, fetch_fault}, 32'd1);
    chk("mis_halted", {31'd0, halted}, 32'd1);
    chk("mis_req",    {31'd0, imem_req}, 32'd0);
    tick;
    chk("mis_req2",   {31'd0, imem_req}, 32'd0);
    chk("mis_fault2", {31'd0, fetch_fault}, 32'd1);
`else
    chk("mis_addr",   imem_addr, 32'h0000_2000);
    chk("mis_req",    {31'd0, imem_req}, 32'd1);
    chk("mis_fault",  {31'd0, fetch_fault}, 32'd0);
    chk("mis_halted", {31'd0, halted}, 32'd0);
`endif

    // halt during outstanding request
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("rst2_fault", {31'd0, fetch_fault}, 32'd0);
    tick;
    chk("h_fetch_addr", imem_addr, 32'h0000_1000);
    halt = 1'b1;
    tick;
    halt = 1'b0;
    chk("hpend_req",    {31'd0, imem_req}, 32'd1);
    chk("hpend_halted", {31'd0, halted}, 32'd0);
    tick;
    chk("hpend2_req", {31'd0, imem_req}, 32'd1);
    imem_ack = 1'b1; imem_rdata = 32'h5555_5555;
    tick;
    imem_ack = 1'b0;
    chk("halt_req",    {31'd0, imem_req}, 32'd0);
    chk("halt_halted", {31'd0, halted}, 32'd1);
    chk("halt_valid",  {31'd0, instr_valid}, 32'd0);
    redirect = 1'b1; redirect_pc = 32'h0000_4000;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("hold_halt_req",    {31'd0, imem_req}, 32'd0);
      chk("hold_halt_halted", {31'd0, halted}, 32'd1);
      chk("hold_halt_valid",  {31'd0, instr_valid}, 32'd0);
      chk("hold_halt_addr",   imem_addr, 32'h0000_1000);
    end
    redirect = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
